// File: rtl/ckpt_fifo_pkg.sv
// Shared sizing helpers for the checkpointed FIFO: pointers carry one extra
// wrap bit above the entry index.
package ckpt_fifo_pkg;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: clear beats load beats increment; wraps modulo 2^PW.
module fifo_ptr #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          clear,
    input  logic          inc,
    input  logic          load,
    input  logic [PW-1:0] load_val,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)     ptr <= '0;
        else if (clear) ptr <= '0;
        else if (load)  ptr <= load_val;
        else if (inc)   ptr <= ptr + PW'(1);
    end

endmodule

// File: rtl/ckpt_fifo.sv
// Show-ahead synchronous FIFO whose read pointer can be checkpointed and
// rewound; checkpointed words stay protected from overwrite until released.
module ckpt_fifo
    import ckpt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    w_enable,
    input  logic                    r_enable,
    input  logic                    store_r_ptr,
    input  logic                    revert_r_ptr,
    input  logic                    release_r_ptr,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PW-1:0] w_ptr, r_ptr, ckpt_ptr, base, used;
    logic          ckpt_held;
    logic          wr_ok, rd_ok, revert_ok;

    // Occupancy counts protected (popped but checkpointed) words too.
    assign base        = ckpt_held ? ckpt_ptr : r_ptr;
    assign used        = w_ptr - base;
    assign full        = (used == DEPTH_P);
    assign empty       = (w_ptr == r_ptr);
    assign almost_full = (used >= AF_P);
    assign count       = w_ptr - r_ptr;
    assign r_data      = mem[r_ptr[AW-1:0]];

    assign revert_ok = revert_r_ptr & ckpt_held;
    assign wr_ok     = w_enable & ~full & ~clear;
    assign rd_ok     = r_enable & ~empty & ~revert_r_ptr & ~clear;

    fifo_ptr #(.PW(PW)) u_w_ptr (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (clear),
        .inc      (wr_ok),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (w_ptr)
    );

    fifo_ptr #(.PW(PW)) u_r_ptr (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (clear),
        .inc      (rd_ok),
        .load     (revert_ok),
        .load_val (ckpt_ptr),
        .ptr      (r_ptr)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mem <= '0;
        end else if (wr_ok) begin
            mem[w_ptr[AW-1:0]] <= w_data;
        end
    end

    // Store snapshots the pre-pop read pointer so this cycle's word is replayable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ckpt_ptr  <= '0;
            ckpt_held <= 1'b0;
        end else if (clear) begin
            ckpt_ptr  <= '0;
            ckpt_held <= 1'b0;
        end else if (revert_ok) begin
            ckpt_held <= 1'b1;
        end else if (store_r_ptr) begin
            ckpt_ptr  <= r_ptr;
            ckpt_held <= 1'b1;
        end else if (release_r_ptr) begin
            ckpt_held <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_enable & full)  overflow  <= 1'b1;
            if (r_enable & empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ckpt_fifo.sv
// Directed and random stimulus against a queue-based model of the
// checkpointed FIFO.
module tb_ckpt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 1;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          clear = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic          w_enable = 1'b0, r_enable = 1'b0;
    logic          store_r_ptr = 1'b0, revert_r_ptr = 1'b0, release_r_ptr = 1'b0;
    logic [DW-1:0] r_data;
    logic          full, empty, almost_full, overflow, underflow;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    // q[0] is the oldest retained word (checkpoint base when held);
    // rd_off words at the front are popped but still protected.
    logic [DW-1:0] q[$];
    int  rd_off = 0;
    bit  held = 0, ovf = 0, unf = 0;

    ckpt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .w_data        (w_data),
        .w_enable      (w_enable),
        .r_enable      (r_enable),
        .store_r_ptr   (store_r_ptr),
        .revert_r_ptr  (revert_r_ptr),
        .release_r_ptr (release_r_ptr),
        .r_data        (r_data),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_rd();
        return q.size() - rd_off;
    endfunction

    function automatic int m_used();
        return held ? q.size() : m_rd();
    endfunction

    task automatic m_reset();
        q.delete();
        rd_off = 0;
        held = 0;
        ovf = 0;
        unf = 0;
    endtask

    task automatic m_drop();
        repeat (rd_off) void'(q.pop_front());
        rd_off = 0;
    endtask

    task automatic m_step(input bit we, input logic [DW-1:0] wd, input bit re,
                          input bit st, input bit rv, input bit rl, input bit cl);
        bit f, e, rd;
        if (cl) begin
            m_reset();
            return;
        end
        f = (m_used() == DEPTH);
        e = (m_rd() == 0);
        if (we && f) ovf = 1;
        if (re && e) unf = 1;
        rd = re && !e && !rv;
        if (rv && held) begin
            rd_off = 0;
        end else if (st) begin
            m_drop();
            held = 1;
        end else if (rl) begin
            m_drop();
            held = 0;
        end
        if (rd) begin
            if (held) rd_off++;
            else void'(q.pop_front());
        end
        if (we && !f) q.push_back(wd);
    endtask

    task automatic chk_all();
        chk("count", 32'(count), 32'(m_rd()));
        chk("empty", 32'(empty), 32'(m_rd() == 0));
        chk("full", 32'(full), 32'(m_used() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(m_used() >= AF));
        chk("overflow", 32'(overflow), 32'(ovf));
        chk("underflow", 32'(underflow), 32'(unf));
        if (m_rd() != 0) chk("r_data", 32'(r_data), 32'(q[rd_off]));
    endtask

    task automatic chk_rst();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        chk("rst_rdata", 32'(r_data), 0);
    endtask

    // Called at a falling edge; inputs settle, the model follows the rising
    // edge, and outputs are compared at the next falling edge.
    task automatic step(input bit we, input logic [DW-1:0] wd, input bit re,
                        input bit st = 0, input bit rv = 0, input bit rl = 0,
                        input bit cl = 0);
        w_enable = we; w_data = wd; r_enable = re;
        store_r_ptr = st; revert_r_ptr = rv; release_r_ptr = rl; clear = cl;
        @(posedge clk);
        m_step(we, wd, re, st, rv, rl, cl);
        @(negedge clk);
        chk_all();
    endtask

    task automatic idle_in();
        w_enable = 0; r_enable = 0; store_r_ptr = 0;
        revert_r_ptr = 0; release_r_ptr = 0; clear = 0;
    endtask

    initial begin
        #12;
        chk_rst();
        m_reset();
        @(negedge clk);
        n_rst = 1'b1;

        // fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) step(1, 8'(i * 17), 0);
        chk("fill_full", 32'(full), 1);
        step(1, 8'h99, 0);
        chk("fill_ovf", 32'(overflow), 1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", 32'(r_data), 32'(i * 17));
            step(0, 0, 1);
        end
        chk("drain_empty", 32'(empty), 1);

        // simultaneous write+read at full and at empty
        for (int i = 0; i < 8; i++) step(1, 8'(8'h40 + i), 0);
        step(1, 8'hEE, 1);
        chk("full_wr_rd_cnt", 32'(count), 7);
        for (int i = 0; i < 7; i++) step(0, 0, 1);
        step(1, 8'h5A, 1);
        chk("empty_wr_rd_cnt", 32'(count), 1);
        step(0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // store, pop twice, revert, pop three
        step(1, 8'hA1, 0); step(1, 8'hA2, 0); step(1, 8'hA3, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1); step(0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("revert_rdata", 32'(r_data), 32'h0A1);
        chk("revert_count", 32'(count), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // back-pressure from checkpoint
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 8'(8'hC0 + i), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        chk("bp_full", 32'(full), 1);
        step(0, 0, 0, 0, 0, 1);
        step(1, 8'hD0, 0);

        // wrap-around pairs
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(i + 3), 0);
            step(0, 0, 1);
        end

        // clear with checkpoint held and overflow set, then revert is a no-op
        step(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1);
        step(1, 8'hFF, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("clr_empty", 32'(empty), 1);
        chk("clr_ovf", 32'(overflow), 0);
        step(0, 0, 0, 0, 1);

        // random traffic with an async reset in the middle
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                #2 n_rst = 1'b0;
                #1 chk_rst();
                m_reset();
                idle_in();
                @(negedge clk);
                n_rst = 1'b1;
            end
            step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 2);
        end
        idle_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ckpt_fifo.md
# ckpt_fifo

Parametrised single-clock synchronous FIFO with show-ahead read data, programmable almost-full threshold, occupancy count, sticky overflow/underflow flags and a read-pointer checkpoint (store / revert / release). Successor to the fixed 8×8 byte FIFO used behind the APB slave bridges. The checkpoint lets a bus slave replay words from a NACKed or aborted transaction, and the write side is back-pressured so checkpointed words are never overwritten.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when occupied-plus-protected entries ≥ AF_LEVEL (1..DEPTH)
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  single clock; all state updates on rising edge
- n_rst  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: pointers, checkpoint and sticky flags to reset values
- w_data  in  DATA_WIDTH  write data
- w_enable  in  1  write request
- r_enable  in  1  read (pop) request
- store_r_ptr  in  1  take checkpoint of read pointer
- revert_r_ptr  in  1  restore read pointer to checkpoint
- release_r_ptr  in  1  drop checkpoint; protected entries become free
- r_data  out  DATA_WIDTH  word at head of FIFO (show-ahead); 0 after reset
- full  out  1  no write can be accepted
- empty  out  1  no word readable
- almost_full  out  1  see AF_LEVEL
- count  out  $clog2(DEPTH)+1  readable words, w_ptr − r_ptr
- overflow  out  1  sticky: write requested while full
- underflow  out  1  sticky: read requested while empty

## Operation
- Pointers w_ptr, r_ptr, ckpt_ptr are AW+1 bits (AW = $clog2(DEPTH)); index = low AW bits, MSB is wrap bit; increment wraps naturally modulo 2·DEPTH.
- base = ckpt_held ? ckpt_ptr : r_ptr; used = w_ptr − base (mod 2·DEPTH).
- full = (used == DEPTH); empty = (w_ptr == r_ptr); almost_full = (used ≥ AF_LEVEL); all combinational from registered state.
- Write accepted (wr_ok) = w_enable & ~full: mem[w_ptr index] ← w_data, w_ptr+1. Rejected write sets overflow.
- Read accepted (rd_ok) = r_enable & ~empty & ~revert_r_ptr: r_ptr+1. r_enable & empty sets underflow.
- Flags evaluated on state at start of cycle; no write-through when full even if a read is accepted the same cycle; no read-through when empty even if a write is accepted.
- Checkpoint priority: clear > revert > store > release.
  - store: ckpt_ptr ← r_ptr (pre-read value; word popped this cycle is replayable), ckpt_held ← 1. Re-store while held moves checkpoint.
  - revert (only when ckpt_held; otherwise ignored): r_ptr ← ckpt_ptr, any read this cycle ignored, ckpt_held stays 1.
  - release: ckpt_held ← 0.
- Writes are independent of checkpoint commands and still accepted the same cycle.
- clear: w_ptr, r_ptr, ckpt_ptr ← 0, ckpt_held ← 0, overflow/underflow ← 0; concurrent write/read dropped; memory contents untouched.

## Timing
- Reset (n_rst low, async): pointers 0, ckpt_held 0, memory 0 → r_data 0, empty 1, full 0, almost_full 0 (1 if AF_LEVEL… never, AF_LEVEL ≥1), count 0, overflow 0, underflow 0.
- Write-to-read latency: word written at edge N is on r_data and empty deasserts after edge N (readable cycle N+1).
- r_data = mem[r_ptr index] combinationally; updates the cycle after a pop or revert.
- All flag/count changes visible the cycle after the causing edge.
- Reset mid-operation discards everything including checkpoint.

## Structure
- Package ckpt_fifo_pkg: AW/pointer-width helper function, pointer type macro-free localparams; no enums needed.
- One sub-module natural: fifo_ptr (AW+1-bit pointer register with increment, load and clear), instantiated for w_ptr and r_ptr; checkpoint register and flag logic in top.
- Memory: DATA_WIDTH×DEPTH flop array with async reset to 0, written one entry per cycle by index decode.

## Test plan
- Reset, then 8 writes 0x11..0x88 (DEPTH=8) → full=1, count=8, almost_full from 7th write; 9th write 0x99 → rejected, overflow=1; 8 reads return 0x11..0x88 in order, then empty=1.
- Simultaneous write+read when full → read accepted, write rejected, count 8→7, overflow=1; when empty → write accepted, read ignored, underflow=1, count 0→1.
- Write 0xA1,0xA2,0xA3; store; pop twice (0xA1,0xA2); revert → r_data=0xA1, count=3; pop three → 0xA1,0xA2,0xA3.
- Checkpoint back-pressure: store at r_ptr=0, fill 8, pop 4 → full stays 1, count=4; release → full=0, next write accepted.
- Wrap-around: 20 write/read pairs interleaved → data ordered, count toggles 0/1, no flags.
- clear with 5 words, checkpoint held and overflow set → next cycle empty=1, count=0, overflow=0, revert has no effect; async n_rst mid-burst → all outputs to reset values immediately.
